// File: rtl/rf_wr_sched.sv
// rf_wr_sched: schedules the single register-file write port between two
// writeback sources (req0 = ALU/load, req1 = mul/div) with round-robin
// arbitration, a registered output stage and a pending-write scoreboard.
// Optional feature macro: RF_SCHED_BYPASS_EN adds staged-write bypass ports.
module rf_wr_sched #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_rd,
  input  logic [XLEN-1:0] req0_wd,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_rd,
  input  logic [XLEN-1:0] req1_wd,
  output logic            req1_ready,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic            haz1,
  output logic            haz2,
  output logic            rf_we,
  output logic [AW-1:0]   rf_rd,
  output logic [XLEN-1:0] rf_wd
`ifdef RF_SCHED_BYPASS_EN
  ,
  output logic            byp1_hit,
  output logic            byp2_hit,
  output logic [XLEN-1:0] byp1_data,
  output logic [XLEN-1:0] byp2_data
`endif
);

  localparam int NREG = 1 << AW;

  logic            rr_ptr;       // 0: req0 favoured on a tie, 1: req1 favoured
  logic            grant0;
  logic            grant1;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  // Arbitration: a lone requester wins; on a tie rr_ptr picks the winner.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | ~rr_ptr);
    grant1 = req1_valid & (~req0_valid |  rr_ptr);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Round-robin pointer: point at the loser after every grant, hold otherwise.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         rr_ptr <= 1'b0;
    else if (grant0) rr_ptr <= 1'b1;
    else if (grant1) rr_ptr <= 1'b0;
  end

`ifdef RF_SCHED_BYPASS_EN
  logic staged_src1;   // staged write came from req1

  // Remember which source owns the staged write, for hazard suppression.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         staged_src1 <= 1'b0;
    else if (grant0) staged_src1 <= 1'b0;
    else if (grant1) staged_src1 <= 1'b1;
  end
`endif

  // Output stage: register the winning write; rd==0 is accepted but never
  // enables the write. With no grant the write enable drops, rd/wd hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (grant0) begin
      rf_we <= (req0_rd != '0);
      rf_rd <= req0_rd;
      rf_wd <= req0_wd;
    end else if (grant1) begin
      rf_we <= (req1_rd != '0);
      rf_rd <= req1_rd;
      rf_wd <= req1_wd;
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Scoreboard next state: clear on accepted req1 write, then set on issue so
  // a same-cycle set of the same register wins. x0 is never pending.
  // NOTE: start from a full default so no path leaves a bit unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    pending_nxt = pending;
    if (grant1) pending_nxt[req1_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0)) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  // NOTE: this is a flop vector, not a RAM, so it is cheap to reset and must
  // be, since a stale pending bit would stall decode forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

`ifdef RF_SCHED_BYPASS_EN
  assign byp1_hit  = rf_we && (rf_rd == rs1) && (rs1 != '0);
  assign byp2_hit  = rf_we && (rf_rd == rs2) && (rs2 != '0);
  assign byp1_data = rf_wd;
  assign byp2_data = rf_wd;
  assign haz1      = pending[rs1] & ~(byp1_hit & staged_src1);
  assign haz2      = pending[rs2] & ~(byp2_hit & staged_src1);
`else
  assign haz1      = pending[rs1];
  assign haz2      = pending[rs2];
`endif

endmodule

// File: tb/tb_rf_wr_sched.sv
// tb_rf_wr_sched: directed stimulus with a behavioural reference model of the
// write scheduler, checked every cycle, plus hand-computed literal checks.
module tb_rf_wr_sched;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid = 1'b0;
  logic [AW-1:0]   req0_rd = '0;
  logic [XLEN-1:0] req0_wd = '0;
  logic            req0_ready;
  logic            req1_valid = 1'b0;
  logic [AW-1:0]   req1_rd = '0;
  logic [XLEN-1:0] req1_wd = '0;
  logic            req1_ready;
  logic            iss_valid = 1'b0;
  logic [AW-1:0]   iss_rd = '0;
  logic [AW-1:0]   rs1 = '0;
  logic [AW-1:0]   rs2 = '0;
  logic            haz1, haz2;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wd;
`ifdef RF_SCHED_BYPASS_EN
  logic            byp1_hit, byp2_hit;
  logic [XLEN-1:0] byp1_data, byp2_data;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  rf_wr_sched #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_wd(req0_wd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_wd(req1_wd), .req1_ready(req1_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .haz1(haz1), .haz2(haz2),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wd(rf_wd)
`ifdef RF_SCHED_BYPASS_EN
    , .byp1_hit(byp1_hit), .byp2_hit(byp2_hit), .byp1_data(byp1_data), .byp2_data(byp2_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Source that won the most recent grant; the other one wins the next tie.
  int              m_last = 1;
  bit              pend [NREG];
  bit              m_we = 1'b0;
  logic [AW-1:0]   m_rd = '0;
  logic [XLEN-1:0] m_wd = '0;
  bit              m_src1 = 1'b0;

  // Which source the arbiter must pick given the current inputs (-1: none).
  function automatic int winner();
    if (req0_valid && req1_valid) return 1 - m_last;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last <= 1;
      m_we   <= 1'b0;
      m_rd   <= '0;
      m_wd   <= '0;
      m_src1 <= 1'b0;
      for (int i = 0; i < NREG; i++) pend[i] <= 1'b0;
    end else begin
      case (winner())
        0: begin
          m_we <= (req0_rd != 0); m_rd <= req0_rd; m_wd <= req0_wd;
          m_src1 <= 1'b0; m_last <= 0;
        end
        1: begin
          m_we <= (req1_rd != 0); m_rd <= req1_rd; m_wd <= req1_wd;
          m_src1 <= 1'b1; m_last <= 1;
          pend[req1_rd] <= 1'b0;
        end
        default: m_we <= 1'b0;
      endcase
      // Issued after the clear, so a same-cycle issue keeps the bit set.
      if (iss_valid && iss_rd != 0) pend[iss_rd] <= 1'b1;
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    int  w;
    bit  h1, h2;
    bit  e_hit1, e_hit2;
    w  = winner();
    h1 = pend[rs1];
    h2 = pend[rs2];
    e_hit1 = m_we && (m_rd == rs1) && (rs1 != 0);
    e_hit2 = m_we && (m_rd == rs2) && (rs2 != 0);
`ifdef RF_SCHED_BYPASS_EN
    if (e_hit1 && m_src1) h1 = 1'b0;
    if (e_hit2 && m_src1) h2 = 1'b0;
    check("cyc_byp1_hit", byp1_hit, e_hit1);
    check("cyc_byp2_hit", byp2_hit, e_hit2);
    if (e_hit1) check("cyc_byp1_data", byp1_data, m_wd);
    if (e_hit2) check("cyc_byp2_data", byp2_data, m_wd);
`endif
    check("cyc_req0_ready", req0_ready, (w == 0));
    check("cyc_req1_ready", req1_ready, (w == 1));
    check("cyc_haz1", haz1, h1);
    check("cyc_haz2", haz2, h2);
    check("cyc_rf_we", rf_we, m_we);
    if (m_we) begin
      check("cyc_rf_rd", rf_rd, m_rd);
      check("cyc_rf_wd", rf_wd, m_wd);
    end
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic reset_pulse();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    int i0, i1, n;
    bit r0, r1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: single req0 write, one-cycle latency to the write port
    check("reset_rf_we", rf_we, 1'b0);
    check("reset_haz1", haz1, 1'b0);
    req0_valid = 1'b1; req0_rd = 5; req0_wd = 32'hA5A5_0001;
    @(negedge clk);
    check("t1_req0_ready", req0_ready, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t1_rf_we", rf_we, 1'b1);
    check("t1_rf_rd", rf_rd, 5);
    check("t1_rf_wd", rf_wd, 32'hA5A5_0001);

    // 2: dual request after reset, held until accepted
    reset_pulse();
    req0_valid = 1'b1; req0_rd = 1; req0_wd = 32'h0000_0011;
    req1_valid = 1'b1; req1_rd = 2; req1_wd = 32'h0000_0022;
    @(negedge clk);
    check("t2_first_ready0", req0_ready, 1'b1);
    check("t2_first_ready1", req1_ready, 1'b0);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t2_second_ready1", req1_ready, 1'b1);
    check("t2_rf_rd_a", rf_rd, 1);
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    check("t2_rf_rd_b", rf_rd, 2);
    check("t2_rf_wd_b", rf_wd, 32'h0000_0022);

    // 3: write to x0 is accepted but never enabled
    next_cycle();
    req0_valid = 1'b1; req0_rd = 0; req0_wd = 32'hFFFF_FFFF;
    @(negedge clk);
    check("t3_req0_ready", req0_ready, 1'b1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t3_rf_we", rf_we, 1'b0);

    // 4: scoreboard set/clear, and same-cycle set wins
    next_cycle();
    iss_valid = 1'b1; iss_rd = 7; rs1 = 7;
    @(negedge clk);
    check("t4_haz1_before", haz1, 1'b0);
    next_cycle();
    iss_valid = 1'b0;
    @(negedge clk);
    check("t4_haz1_set", haz1, 1'b1);
    next_cycle();
    req1_valid = 1'b1; req1_rd = 7; req1_wd = 32'h0000_0077;
    @(negedge clk);
    check("t4_haz1_at_accept", haz1, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    check("t4_haz1_cleared", haz1, 1'b0);
    check("t4_rf_rd", rf_rd, 7);
    next_cycle();
    iss_valid = 1'b1; iss_rd = 7;
    next_cycle();
    req1_valid = 1'b1; req1_rd = 7; req1_wd = 32'h0000_0078;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t4_same_cycle_set_wins", haz1, 1'b1);
    next_cycle();
    req1_valid = 1'b1; req1_rd = 7; req1_wd = 32'h0000_0079;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t4_final_clear", haz1, 1'b0);

    // 5: asynchronous reset mid-write clears stage, mask and pointer
    next_cycle();
    iss_valid = 1'b1; iss_rd = 12; rs1 = 12;
    req0_valid = 1'b1; req0_rd = 9; req0_wd = 32'h0000_0099;
    next_cycle();
    idle_inputs();
    @(negedge clk);
    check("t5_haz1_pre", haz1, 1'b1);
    @(posedge clk); #2;
    // the post-edge stage is empty; re-stage a write to interrupt
    req0_valid = 1'b1; req0_rd = 9;
    next_cycle();
    req0_valid = 1'b0;
    #1;
    check("t5_rf_we_pre", rf_we, 1'b1);
    rst = 1'b1;
    #1;
    check("t5_rf_we_async", rf_we, 1'b0);
    check("t5_haz1_async", haz1, 1'b0);
    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b1; req0_rd = 3; req0_wd = 32'h0000_0033;
    req1_valid = 1'b1; req1_rd = 4; req1_wd = 32'h0000_0044;
    @(negedge clk);
    check("t5_ready0_after_rst", req0_ready, 1'b1);
    check("t5_ready1_after_rst", req1_ready, 1'b0);
    next_cycle();
    req0_valid = 1'b0;
    next_cycle();
    idle_inputs();

    // 6: staged req1 write visible to decode (bypass build checks the ports)
    iss_valid = 1'b1; iss_rd = 3; rs2 = 3;
    next_cycle();
    iss_valid = 1'b0;
    req1_valid = 1'b1; req1_rd = 3; req1_wd = 32'h0000_1234;
    @(negedge clk);
    check("t6_haz2_pending", haz2, 1'b1);
    next_cycle();
    req1_valid = 1'b0;
    @(negedge clk);
    check("t6_haz2", haz2, 1'b0);
`ifdef RF_SCHED_BYPASS_EN
    check("t6_byp2_hit", byp2_hit, 1'b1);
    check("t6_byp2_data", byp2_data, 32'h0000_1234);
`endif

    // Streams: both sources busy, advancing only on acceptance
    i0 = 0; i1 = 0; n = 0;
    rs1 = 10; rs2 = 11;
    while ((i0 < 4 || i1 < 4) && n < 20) begin
      next_cycle();
      req0_valid = (i0 < 4);
      req0_rd    = AW'(i0 == 2 ? 0 : i0 + 1);
      req0_wd    = 32'h100 + XLEN'(i0);
      req1_valid = (i1 < 4);
      req1_rd    = AW'(10 + i1);
      req1_wd    = 32'h200 + XLEN'(i1);
      iss_valid  = (n < 4);
      iss_rd     = AW'(10 + n);
      @(negedge clk);
      r0 = req0_ready; r1 = req1_ready;
      if (r0) i0++;
      if (r1) i1++;
      n++;
    end
    check("stream_done", i0 + i1, 8);
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
